// File: rtl/fetch_pc_gen.sv
// Frontend PC generator: issues line-sized fetch requests with redirect priority,
// in-order response tracking and stale-response dropping. Optional perf counters: FETCH_PC_GEN_PERF_CNT_EN.
module fetch_pc_gen #(
  parameter int PC_W       = 48,
  parameter int LINE_BYTES = 64,
  parameter int IDX_LO     = 3,
  parameter int IDX_W      = 19,
  parameter int MAX_OUTST  = 4,
  parameter int NUM_REDIR  = 2,
  localparam int OW        = $clog2(MAX_OUTST+1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PC_W-1:0]           boot_addr,
  input  logic [NUM_REDIR-1:0]      redir_valid,
  input  logic [NUM_REDIR*PC_W-1:0] redir_addr,
  input  logic                      fetch_req,
  output logic                      req_valid,
  input  logic                      req_ready,
  output logic [IDX_W-1:0]          req_index,
  output logic [PC_W-1:0]           req_pc,
  input  logic                      resp_valid,
  output logic                      resp_keep,
  output logic [OW-1:0]             outst_cnt,
  output logic                      err_resp_underflow,
  output logic [31:0]               issued_cnt,
  output logic [31:0]               dropped_cnt
);

  localparam logic [PC_W-1:0] LINE_MASK = PC_W'(LINE_BYTES-1);
  localparam logic [OW-1:0]   OUTST_MAX = OW'(MAX_OUTST);

  typedef enum logic {S_BOOT, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            req_valid_q, req_valid_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [OW-1:0]   drop_q, drop_d;
  logic            err_q, err_d;

  logic            run, hs, resp_eff, redir_any, drop_resp;
  logic [PC_W-1:0] redir_tgt;

  // Walk from the highest index down so the lowest set source wins.
  always_comb begin
    redir_tgt = '0;
    for (int i = NUM_REDIR-1; i >= 0; i--)
      if (redir_valid[i]) redir_tgt = redir_addr[i*PC_W +: PC_W];
  end

  always_comb begin
    run       = (state_q == S_RUN);
    redir_any = run && (|redir_valid);
    hs        = req_valid_q && req_ready;
    // A response with nothing outstanding is an error and must not wrap the count.
    resp_eff  = resp_valid && (outst_q != '0);
    drop_resp = resp_valid && (drop_q != '0);
    outst_d   = outst_q + OW'(hs) - OW'(resp_eff);
    err_d     = err_q | (resp_valid && (outst_q == '0));
    state_d   = S_RUN;

    pc_d = pc_q;
    if (!run)          pc_d = boot_addr;
    else if (redir_any) pc_d = redir_tgt;
    else if (hs)       pc_d = (pc_q & ~LINE_MASK) + PC_W'(LINE_BYTES);

    req_valid_d = 1'b0;
    if (run && !redir_any) begin
      if (req_valid_q && !hs) req_valid_d = 1'b1;
      else                    req_valid_d = fetch_req && (outst_d < OUTST_MAX);
    end

    drop_d = drop_q;
    if (redir_any)      drop_d = outst_d;
    else if (drop_resp) drop_d = drop_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_BOOT;
      pc_q        <= '0;
      req_valid_q <= 1'b0;
      outst_q     <= '0;
      drop_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
    end
  end

  assign req_valid          = req_valid_q;
  assign req_pc             = pc_q;
  assign req_index          = pc_q[IDX_LO +: IDX_W];
  assign outst_cnt          = outst_q;
  assign err_resp_underflow = err_q;
  assign resp_keep          = resp_valid && (drop_q == '0);

`ifdef FETCH_PC_GEN_PERF_CNT_EN
  logic [31:0] issued_cnt_q, issued_cnt_d, dropped_cnt_q, dropped_cnt_d;

  always_comb begin
    issued_cnt_d  = issued_cnt_q + 32'(hs);
    dropped_cnt_d = dropped_cnt_q + 32'(drop_resp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt_q  <= '0;
      dropped_cnt_q <= '0;
    end else begin
      issued_cnt_q  <= issued_cnt_d;
      dropped_cnt_q <= dropped_cnt_d;
    end
  end

  assign issued_cnt  = issued_cnt_q;
  assign dropped_cnt = dropped_cnt_q;
`else
  assign issued_cnt  = '0;
  assign dropped_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: boot, sequential issue, backpressure, redirects, wrap, underflow.
module tb_fetch_pc_gen;
  localparam int PC_W = 48;
  localparam int IDX_W = 19;
  localparam int NR = 2;
  localparam int OW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PC_W-1:0]   boot_addr;
  logic [NR-1:0]     redir_valid;
  logic [NR*PC_W-1:0] redir_addr;
  logic              fetch_req, req_valid, req_ready, resp_valid, resp_keep, err_resp_underflow;
  logic [IDX_W-1:0]  req_index;
  logic [PC_W-1:0]   req_pc;
  logic [OW-1:0]     outst_cnt;
  logic [31:0]       issued_cnt, dropped_cnt;

  int checks = 0;
  int failures = 0;

`ifdef FETCH_PC_GEN_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  fetch_pc_gen dut (
    .clk(clk), .rst_n(rst_n), .boot_addr(boot_addr), .redir_valid(redir_valid),
    .redir_addr(redir_addr), .fetch_req(fetch_req), .req_valid(req_valid),
    .req_ready(req_ready), .req_index(req_index), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_keep(resp_keep), .outst_cnt(outst_cnt),
    .err_resp_underflow(err_resp_underflow), .issued_cnt(issued_cnt),
    .dropped_cnt(dropped_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; boot_addr = 48'h1000; redir_valid = '0; redir_addr = '0;
    fetch_req = 1'b0; req_ready = 1'b0; resp_valid = 1'b0;
    step(); step();
    chk("rst_req_valid", 64'(req_valid), 64'h0);
    chk("rst_req_pc", 64'(req_pc), 64'h0);
    chk("rst_outst", 64'(outst_cnt), 64'h0);
    chk("rst_err", 64'(err_resp_underflow), 64'h0);
    chk("rst_issued", 64'(issued_cnt), 64'h0);
    chk("rst_dropped", 64'(dropped_cnt), 64'h0);

    // Test 1: sequential issue up to the outstanding limit
    rst_n = 1'b1; fetch_req = 1'b1; req_ready = 1'b1;
    step();
    chk("boot_no_req", 64'(req_valid), 64'h0);
    step();
    chk("first_index", 64'(req_index), 64'h200);
    for (int i = 0; i < 4; i++) begin
      chk("seq_valid", 64'(req_valid), 64'h1);
      chk("seq_pc", 64'(req_pc), 64'h1000 + 64'(i) * 64'h40);
      step();
    end
    chk("full_valid", 64'(req_valid), 64'h0);
    chk("full_outst", 64'(outst_cnt), 64'h4);
    step();
    chk("full_hold", 64'(req_valid), 64'h0);

    // Test 2: one response frees a slot
    resp_valid = 1'b1;
    #1 chk("t2_keep", 64'(resp_keep), 64'h1);
    step();
    resp_valid = 1'b0; req_ready = 1'b0;
    chk("t2_outst", 64'(outst_cnt), 64'h3);
    chk("t2_valid", 64'(req_valid), 64'h1);
    chk("t2_pc", 64'(req_pc), 64'h1100);

    // Test 4: stall holds the request, then a redirect replaces it
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", 64'(req_valid), 64'h1);
      chk("stall_pc", 64'(req_pc), 64'h1100);
      chk("stall_index", 64'(req_index), 64'h220);
    end
    redir_valid = 2'b10; redir_addr = {48'h2000, 48'hDEAD0};
    step();
    redir_valid = '0;
    chk("t4_withdraw", 64'(req_valid), 64'h0);
    step();
    chk("t4_valid", 64'(req_valid), 64'h1);
    chk("t4_pc", 64'(req_pc), 64'h2000);
    // three stale responses from the 0x1xxx stream
    for (int i = 0; i < 3; i++) begin
      resp_valid = 1'b1;
      #1 chk("t4_drop_keep", 64'(resp_keep), 64'h0);
      step();
    end
    resp_valid = 1'b0;
    chk("t4_drained", 64'(outst_cnt), 64'h0);
    chk("t4_still_pc", 64'(req_pc), 64'h2000);

    // Test 3: both sources redirect, index 0 wins, two responses dropped
    req_ready = 1'b1;
    step(); step();
    chk("t3_outst2", 64'(outst_cnt), 64'h2);
    chk("t3_pc_pre", 64'(req_pc), 64'h2080);
    req_ready = 1'b0; redir_valid = 2'b11; redir_addr = {48'h9000, 48'h8000};
    step();
    redir_valid = '0; req_ready = 1'b1;
    chk("t3_withdraw", 64'(req_valid), 64'h0);
    step();
    chk("t3_pc", 64'(req_pc), 64'h8000);
    step();
    req_ready = 1'b0;
    chk("t3_pc_next", 64'(req_pc), 64'h8040);
    chk("t3_outst3", 64'(outst_cnt), 64'h3);
    resp_valid = 1'b1;
    #1 chk("t3_drop0", 64'(resp_keep), 64'h0);
    step();
    #1 chk("t3_drop1", 64'(resp_keep), 64'h0);
    step();
    #1 chk("t3_keep", 64'(resp_keep), 64'h1);
    step();
    resp_valid = 1'b0;
    chk("t3_outst0", 64'(outst_cnt), 64'h0);

    // Test 5: wrap-around, then an unaligned redirect
    redir_valid = 2'b01; redir_addr = {48'h0, 48'hFFFF_FFFF_FFC0};
    step();
    redir_valid = '0;
    step();
    chk("t5_top_pc", 64'(req_pc), 64'hFFFF_FFFF_FFC0);
    req_ready = 1'b1;
    step();
    chk("t5_wrap_pc", 64'(req_pc), 64'h0);
    chk("t5_wrap_valid", 64'(req_valid), 64'h1);
    redir_valid = 2'b01; redir_addr = {48'h0, 48'h1234};
    step();
    redir_valid = '0;
    chk("t5_redir_valid", 64'(req_valid), 64'h0);
    chk("t5_outst", 64'(outst_cnt), 64'h2);
    step();
    chk("t5_unal_pc", 64'(req_pc), 64'h1234);
    chk("t5_unal_index", 64'(req_index), 64'h246);
    step();
    req_ready = 1'b0;
    chk("t5_aligned_pc", 64'(req_pc), 64'h1240);
    chk("perf_issued", 64'(issued_cnt), PERF ? 64'd10 : 64'd0);
    chk("perf_dropped", 64'(dropped_cnt), PERF ? 64'd5 : 64'd0);

    // Mid-operation reset, redirect during BOOT, then underflow
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outst", 64'(outst_cnt), 64'h0);
    chk("mid_rst_valid", 64'(req_valid), 64'h0);
    chk("mid_rst_issued", 64'(issued_cnt), 64'h0);
    fetch_req = 1'b0; boot_addr = 48'h3000;
    redir_valid = 2'b01; redir_addr = {48'h0, 48'h5000};
    @(negedge clk);
    rst_n = 1'b1;
    step();
    redir_valid = '0;
    resp_valid = 1'b1;
    step();
    resp_valid = 1'b0;
    chk("t6_err", 64'(err_resp_underflow), 64'h1);
    chk("t6_outst", 64'(outst_cnt), 64'h0);
    step();
    chk("t6_err_sticky", 64'(err_resp_underflow), 64'h1);
    fetch_req = 1'b1;
    step();
    chk("boot_redir_ignored", 64'(req_pc), 64'h3000);
    chk("boot_valid", 64'(req_valid), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
